// File: rtl/lutram_fifo_ctrl.sv
// lutram_fifo_ctrl
//   Control stage wrapped around a dual-port LUTRAM. It drives the storage
//   write port and the asynchronous read address. It also registers the read
//   data into a head-of-queue output, which gives a first-word-fall-through
//   FIFO. Capacity is 2**addr_width RAM entries plus the output register.
//
//   Ports:
//     CLK, RST_N       clock (rising edge), async active-low reset
//     CLR              synchronous flush; has priority over ENQ/DEQ
//     ENQ, D_IN        enqueue request / payload; NOT_FULL = enqueue permitted
//     DEQ              dequeue request; NOT_EMPTY = D_OUT valid
//     D_OUT            registered head-of-queue data
//     RAM_ADDR_W/D_W/WE  storage write port
//     RAM_ADDR_R/D_R     storage async read port
//     LEVEL            (only with LUTRAM_FIFO_LEVEL_EN) registered occupancy,
//                      RAM entries plus the output register, 0..D+1
//
//   Optional feature macro: LUTRAM_FIFO_LEVEL_EN adds the LEVEL output.
module lutram_fifo_ctrl #(
  parameter int addr_width = 4,
  parameter int data_width = 32
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  CLR,
  input  logic                  ENQ,
  input  logic [data_width-1:0] D_IN,
  output logic                  NOT_FULL,
  input  logic                  DEQ,
  output logic [data_width-1:0] D_OUT,
  output logic                  NOT_EMPTY,
  output logic [addr_width-1:0] RAM_ADDR_W,
  output logic [data_width-1:0] RAM_D_W,
  output logic                  RAM_WE,
  output logic [addr_width-1:0] RAM_ADDR_R,
  input  logic [data_width-1:0] RAM_D_R
`ifdef LUTRAM_FIFO_LEVEL_EN
  ,
  output logic [addr_width:0]   LEVEL
`endif
);

  localparam int D = 2**addr_width;

  logic [addr_width-1:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic [addr_width:0]   cnt, cnt_nxt;
  logic                  out_valid, ov_nxt;
  logic [data_width-1:0] out_reg, out_nxt;
  logic                  enq_ok, deq_ok, bypass, ram_rd;

  assign NOT_FULL  = cnt < (addr_width+1)'(D);
  assign NOT_EMPTY = out_valid;
  assign D_OUT     = out_reg;

  assign enq_ok = ENQ & NOT_FULL;
  assign deq_ok = DEQ & NOT_EMPTY;
  // The RAM is empty and the output register is free (or is freed this
  // cycle), so the new word goes straight to D_OUT and skips the RAM.
  assign bypass = enq_ok & (cnt == '0) & (~out_valid | deq_ok);
  assign ram_rd = deq_ok & (cnt != '0);

  assign RAM_WE     = enq_ok & ~bypass & ~CLR;
  assign RAM_ADDR_W = wr_ptr;
  assign RAM_D_W    = D_IN;
  // wr_ptr == rd_ptr only when the RAM is empty (bypass, no read) or full
  // (write blocked), so the async read never sees a same-cycle write.
  assign RAM_ADDR_R = rd_ptr;

  always_comb begin
    wr_nxt  = wr_ptr;
    rd_nxt  = rd_ptr;
    cnt_nxt = cnt;
    ov_nxt  = out_valid;
    out_nxt = out_reg;
    if (CLR) begin
      // out_reg keeps its value on a flush; only the valid flag drops.
      wr_nxt  = '0;
      rd_nxt  = '0;
      cnt_nxt = '0;
      ov_nxt  = 1'b0;
    end else begin
      if (RAM_WE) wr_nxt = wr_ptr + addr_width'(1);
      if (ram_rd) begin
        rd_nxt  = rd_ptr + addr_width'(1);
        out_nxt = RAM_D_R;
      end
      // bypass and ram_rd are mutually exclusive (cnt==0 vs cnt>0).
      if (bypass) begin
        out_nxt = D_IN;
        ov_nxt  = 1'b1;
      end else if (deq_ok && cnt == '0) begin
        ov_nxt  = 1'b0;
      end
      cnt_nxt = cnt + (addr_width+1)'(RAM_WE) - (addr_width+1)'(ram_rd);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_reg   <= '0;
    end else begin
      wr_ptr    <= wr_nxt;
      rd_ptr    <= rd_nxt;
      cnt       <= cnt_nxt;
      out_valid <= ov_nxt;
      out_reg   <= out_nxt;
    end
  end

`ifdef LUTRAM_FIFO_LEVEL_EN
  // Registered from next-state values, so LEVEL tracks cnt + out_valid
  // with no extra cycle of lag.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) LEVEL <= '0;
    else        LEVEL <= cnt_nxt + (addr_width+1)'(ov_nxt);
  end
`endif

endmodule

// File: tb/tb_lutram_fifo_ctrl.sv
module tb_lutram_fifo_ctrl;
  localparam int AW = 2;
  localparam int DW = 8;
  localparam int CAP = 5;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          CLR = 1'b0, ENQ = 1'b0, DEQ = 1'b0;
  logic [DW-1:0] D_IN = '0;
  logic          NOT_FULL, NOT_EMPTY, RAM_WE;
  logic [DW-1:0] D_OUT, RAM_D_W, RAM_D_R;
  logic [AW-1:0] RAM_ADDR_W, RAM_ADDR_R;
`ifdef LUTRAM_FIFO_LEVEL_EN
  logic [AW:0]   LEVEL;
`endif

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  lutram_fifo_ctrl #(.addr_width(AW), .data_width(DW)) dut (
    .CLK(CLK), .RST_N(RST_N), .CLR(CLR), .ENQ(ENQ), .D_IN(D_IN),
    .NOT_FULL(NOT_FULL), .DEQ(DEQ), .D_OUT(D_OUT), .NOT_EMPTY(NOT_EMPTY),
    .RAM_ADDR_W(RAM_ADDR_W), .RAM_D_W(RAM_D_W), .RAM_WE(RAM_WE),
    .RAM_ADDR_R(RAM_ADDR_R), .RAM_D_R(RAM_D_R)
`ifdef LUTRAM_FIFO_LEVEL_EN
    , .LEVEL(LEVEL)
`endif
  );

  // Storage stub: sync write, async read.
  logic [DW-1:0] ram [4];
  always @(posedge CLK) if (RAM_WE) ram[RAM_ADDR_W] <= RAM_D_W;
  assign RAM_D_R = ram[RAM_ADDR_R];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: an ordered queue of up to CAP words. The head is what
  // D_OUT must show; RAM traffic is counted as writes/reads mod depth.
  logic [DW-1:0] q[$];
  logic [DW-1:0] dout_m = '0;
  int            wcnt = 0, rcnt = 0;

  function automatic bit m_enq_ok(); return ENQ && q.size() < CAP; endfunction
  function automatic bit m_deq_ok(); return DEQ && q.size() > 0; endfunction
  // A word is written to RAM unless it lands directly in the head slot:
  // the FIFO is empty, or holds one word that is dequeued this cycle.
  function automatic bit m_we();
    return !CLR && m_enq_ok() &&
           !(q.size() == 0 || (q.size() == 1 && m_deq_ok()));
  endfunction

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      q.delete(); dout_m = '0; wcnt = 0; rcnt = 0;
    end else if (CLR) begin
      q.delete(); wcnt = 0; rcnt = 0;
    end else begin
      automatic bit e = m_enq_ok();
      automatic bit d = m_deq_ok();
      if (m_we()) wcnt++;
      if (d && q.size() >= 2) rcnt++;
      if (d) void'(q.pop_front());
      if (e) q.push_back(D_IN);
      if (q.size() > 0) dout_m = q[0];
    end
  end

  // Compare process: outputs checked every cycle away from the active edge.
  always @(negedge CLK) begin
    if (RST_N) begin
      chk("not_empty", NOT_EMPTY, q.size() > 0);
      chk("not_full",  NOT_FULL,  q.size() < CAP);
      chk("d_out",     D_OUT,     dout_m);
      chk("ram_we",    RAM_WE,    m_we());
      chk("ram_addr_w", RAM_ADDR_W, wcnt % 4);
      chk("ram_addr_r", RAM_ADDR_R, rcnt % 4);
      chk("ram_d_w",   RAM_D_W,   D_IN);
`ifdef LUTRAM_FIFO_LEVEL_EN
      chk("level",     LEVEL,     q.size());
`endif
    end
  end

  logic we_seen;
  task automatic cyc(input bit e, input logic [DW-1:0] d, input bit dq, input bit c);
    ENQ = e; D_IN = d; DEQ = dq; CLR = c;
    @(negedge CLK); we_seen = RAM_WE;
    @(posedge CLK); #1;
    ENQ = 0; DEQ = 0; CLR = 0; D_IN = '0;
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;
    // Reset state
    chk("rst_not_empty", NOT_EMPTY, 0);
    chk("rst_not_full",  NOT_FULL,  1);
    chk("rst_d_out",     D_OUT,     0);
    chk("rst_ram_we",    RAM_WE,    0);

    // Bypass enqueue into empty FIFO
    cyc(1, 8'hA5, 0, 0);
    chk("byp_we", we_seen, 0);
    chk("byp_ne", NOT_EMPTY, 1);
    chk("byp_dout", D_OUT, 8'hA5);
    cyc(0, 0, 1, 0);
    chk("drain_ne", NOT_EMPTY, 0);
    chk("drain_hold", D_OUT, 8'hA5);

    // Fill to capacity, overflow ignored, drain in order
    for (int i = 1; i <= 5; i++) cyc(1, 8'(i), 0, 0);
    chk("full_nf", NOT_FULL, 0);
    chk("full_dout", D_OUT, 1);
    cyc(1, 8'd6, 0, 0);
    chk("ovf_we", we_seen, 0);
    chk("ovf_dout", D_OUT, 1);
    for (int i = 1; i <= 5; i++) begin
      chk("seq_dout", D_OUT, i);
      cyc(0, 0, 1, 0);
    end
    chk("empty_ne", NOT_EMPTY, 0);

    // Full with simultaneous ENQ+DEQ: ENQ rejected
    for (int i = 1; i <= 5; i++) cyc(1, 8'(i), 0, 0);
    cyc(1, 8'd9, 1, 0);
    chk("fulldq_we", we_seen, 0);
    chk("fulldq_dout", D_OUT, 2);
`ifdef LUTRAM_FIFO_LEVEL_EN
    chk("fulldq_level", LEVEL, 4);
`endif
    for (int i = 3; i <= 5; i++) begin
      cyc(0, 0, 1, 0);
      chk("fulldq_seq", D_OUT, i);
    end
    cyc(0, 0, 1, 0);
    chk("fulldq_empty", NOT_EMPTY, 0);

    // Streaming with two resident entries, pointers wrap
    cyc(1, 8'd10, 0, 0);
    cyc(1, 8'd11, 0, 0);
    for (int i = 0; i < 12; i++) begin
      cyc(1, 8'(20 + i), 1, 0);
      chk("stream_dout", D_OUT, (i == 0) ? 11 : 20 + i - 1);
    end
    cyc(0, 0, 1, 0);
    chk("stream_last", D_OUT, 31);
    cyc(0, 0, 1, 0);
    chk("stream_empty", NOT_EMPTY, 0);

    // Single entry, DEQ+ENQ same cycle -> bypass
    cyc(1, 8'd7, 0, 0);
    cyc(1, 8'd8, 1, 0);
    chk("swap_we", we_seen, 0);
    chk("swap_dout", D_OUT, 8);
    chk("swap_ne", NOT_EMPTY, 1);
    cyc(0, 0, 1, 0);

    // CLR beats ENQ
    for (int i = 1; i <= 3; i++) cyc(1, 8'(i), 0, 0);
    cyc(1, 8'd4, 0, 1);
    chk("clr_we", we_seen, 0);
    chk("clr_ne", NOT_EMPTY, 0);
    chk("clr_nf", NOT_FULL, 1);
    chk("clr_dout_hold", D_OUT, 1);
`ifdef LUTRAM_FIFO_LEVEL_EN
    chk("clr_level", LEVEL, 0);
`endif
    cyc(1, 8'h40, 0, 0);
    cyc(1, 8'h41, 0, 0);
    chk("postclr_dout", D_OUT, 8'h40);

    // Asynchronous reset mid-stream
    ENQ = 1; D_IN = 8'h42;
    #2 RST_N = 1'b0;
    #1;
    chk("arst_ne", NOT_EMPTY, 0);
    chk("arst_nf", NOT_FULL, 1);
    chk("arst_dout", D_OUT, 0);
    chk("arst_we", RAM_WE, 0);
    ENQ = 0; D_IN = '0;
    @(posedge CLK); #1 RST_N = 1'b1;
    cyc(1, 8'h55, 0, 0);
    cyc(1, 8'h56, 0, 0);
    cyc(0, 0, 1, 0);
    chk("postrst_dout", D_OUT, 8'h56);
    cyc(0, 0, 1, 0);
    chk("postrst_empty", NOT_EMPTY, 0);

    @(posedge CLK); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
